// File: rtl/adc_multi_capture.sv
// adc_multi_capture: round-robin XADC DRP reader with optional averaging,
// DRP timeout reporting and per-channel one-cycle valid strobes.
module adc_multi_capture #(
  parameter int NUM_CH = 2,
  parameter logic [7*NUM_CH-1:0] CH_ADDR = {7'h1B, 7'h13},
  parameter int AVG_LOG2 = 0,
  parameter int OUT_W = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  output logic [6:0]              daddr,
  output logic                    den,
  output logic                    dwe,
  input  logic [15:0]             drp_do,
  input  logic                    drdy,
  output logic [OUT_W*NUM_CH-1:0] ch_data,
  output logic [NUM_CH-1:0]       ch_valid,
  output logic                    timeout_err,
  output logic [2:0]              timeout_ch
);
  localparam int AW = 12 + AVG_LOG2;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, ACC} state_t;
  state_t state, state_nx;
  logic [2:0] idx, idx_nx;
  logic [15:0] cnt;
  logic [11:0] sample;
  logic [AW-1:0] acc, total;
  logic [4:0] scnt;
  logic [6:0] addr_sel;
  logic timed_out, last, start, unused_lsb;
  assign dwe = 1'b0;
  assign unused_lsb = ^drp_do[3:0];
  assign start = state == IDLE && enable;
  assign idx_nx = (idx == 3'(NUM_CH - 1)) ? 3'd0 : idx + 3'd1;
  // den is high during REQ, so a decision taken at cnt lands cnt+2 cycles after den
  assign timed_out = state == WAIT && !drdy && 32'(cnt) + 32'd2 >= 32'(TIMEOUT);
  assign total = acc + AW'(sample);
  assign last = scnt == 5'((1 << AVG_LOG2) - 1);
  always_comb begin
    addr_sel = CH_ADDR[6:0];
    for (int i = 0; i < NUM_CH; i++)
      if (idx == 3'(i)) addr_sel = CH_ADDR[7*i +: 7];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = enable ? REQ : IDLE;
      REQ:     state_nx = WAIT;
      WAIT:    state_nx = drdy ? ACC : (timed_out ? IDLE : WAIT);
      ACC:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      daddr       <= CH_ADDR[6:0];
      den         <= 1'b0;
      ch_data     <= '0;
      ch_valid    <= '0;
      timeout_err <= 1'b0;
      timeout_ch  <= 3'd0;
      idx         <= 3'd0;
      cnt         <= 16'd0;
      sample      <= 12'd0;
      acc         <= '0;
      scnt        <= 5'd0;
    end else begin
      den      <= start;
      ch_valid <= '0;
      cnt      <= state == WAIT ? cnt + 16'd1 : 16'd0;
      if (start) daddr <= addr_sel;
      if (state == WAIT && drdy) sample <= drp_do[15:4];
      if (timed_out) begin
        timeout_err <= 1'b1;
        timeout_ch  <= idx;
        acc         <= '0;
        scnt        <= 5'd0;
        idx         <= idx_nx;
      end
      if (state == ACC && last) begin
        for (int i = 0; i < NUM_CH; i++)
          if (idx == 3'(i)) begin
            ch_data[OUT_W*i +: OUT_W] <= OUT_W'(total >> AVG_LOG2);
            ch_valid[i]               <= 1'b1;
          end
        acc  <= '0;
        scnt <= 5'd0;
        idx  <= idx_nx;
      end else if (state == ACC) begin
        acc  <= total;
        scnt <= scnt + 5'd1;
      end
    end
endmodule

// File: doc/adc_multi_capture.md
# adc_multi_capture

Parametrised multi-channel XADC capture sequencer.
- Round-robins DRP reads over a configurable list of NUM_CH auxiliary-channel addresses.
- Optionally averages 2^AVG_LOG2 samples per channel and publishes each result as a zero-extended OUT_W-bit word with a one-cycle valid strobe.
- Sits between an externally instantiated XADC wizard (DRP master side) and the signal-processing datapath (EMG/ECG/other biosignal filters).
- Adds a DRP timeout with error reporting, an enable, and per-channel valid signalling.

## Interface
- NUM_CH, 2: number of channels sequenced, 1..8.
- CH_ADDR, {7'h1B, 7'h13}: packed DRP addresses; channel i uses bits [7*i+6:7*i], and channel 0 is read first.
- AVG_LOG2, 0: log2 of the samples averaged per result, 0..4.
- OUT_W, 32: result width, ≥12.
- TIMEOUT, 255: maximum cycles to wait for drdy after den, 1..65535.

- clk  in  1  single clock for the block and the DRP.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  sequencer runs while high.
- daddr  out  7  DRP address.
- den  out  1  DRP enable, one-cycle pulse.
- dwe  out  1  tied 0 (read-only).
- drp_do  in  16  DRP read data; the ADC code is in [15:4].
- drdy  in  1  DRP data ready.
- ch_data  out  OUT_W*NUM_CH  latest result per channel; channel i is at [OUT_W*i +: OUT_W].
- ch_valid  out  NUM_CH  one-cycle pulse when the corresponding ch_data slice updates.
- timeout_err  out  1  sticky; set on any DRP timeout and cleared only by reset.
- timeout_ch  out  3  index of the channel that last timed out.

## Operation
- FSM states: IDLE, REQ, WAIT, ACC.
- IDLE: if enable=1, go to REQ with the current channel index `idx` (0 after reset).
- REQ: daddr = CH_ADDR[idx] and den=1 for exactly one cycle. daddr is stable from REQ until drdy or timeout. Go to WAIT and clear the wait counter.
- WAIT, drdy=1: capture drp_do[15:4] and go to ACC.
- WAIT, counter reaches TIMEOUT with no drdy: set timeout_err, set timeout_ch=idx, discard any partial accumulation for idx, zero the sample count, then advance idx. ch_data and ch_valid are not touched. Go to IDLE.
- ACC: accumulator += 12-bit sample. The accumulator is 12+AVG_LOG2 bits wide and cannot overflow.
  - If sample count = 2^AVG_LOG2 − 1: ch_data slice idx ← zero-extend(acc_total >> AVG_LOG2), pulse ch_valid[idx], clear the accumulator and count, and advance idx.
  - Else: increment the count and keep idx, so the same channel is resampled.
  - Go to IDLE.
- idx advance: idx+1, wrapping from NUM_CH−1 to 0. NUM_CH=1 always reads channel 0.
- AVG_LOG2=0 means every sample is published directly, i.e. {zeros, drp_do[15:4]}.
- The accumulator and sample count are per-sequencer, not per-channel. Averaging completes on a channel before advancing.
- enable deassertion is sampled only in IDLE. An in-flight read (REQ/WAIT/ACC) always completes or times out first; the FSM then parks in IDLE with idx and accumulation state preserved.
- drdy outside WAIT is ignored.
- Reset mid-operation: all state returns to reset values immediately and asynchronously. Any pending DRP response after reset is ignored because the FSM is not in WAIT.

## Timing
- Reset values: daddr=CH_ADDR[6:0], den=0, dwe=0, ch_data=0, ch_valid=0, timeout_err=0, timeout_ch=0, FSM=IDLE, idx=0, accumulator and count = 0.
- All outputs are registered.
- den rises the cycle after IDLE with enable=1.
- If drdy is seen k cycles after den (k≥1), ch_valid pulses k+2 cycles after den when that sample completes an average.
- Minimum cycle per sample with drdy at k=1 is 4 cycles: IDLE, REQ, WAIT, ACC.
- A timeout is declared TIMEOUT cycles after den. The FSM is in IDLE on the next cycle.
- ch_valid is high for exactly one cycle, and at most one bit is set at a time.

## Test plan
- NUM_CH=2, AVG_LOG2=0, DRP model answers 1 cycle after den: ch0 with 16'hABC0, ch1 with 16'h1230.
  - daddr alternates 13h/1Bh.
  - ch_data[31:0]=32'h00000ABC with ch_valid=01, then ch_data[63:32]=32'h00000123 with ch_valid=10.
  - den pulses every 4 cycles.
- AVG_LOG2=2, NUM_CH=1, samples 12'h100, 12'h101, 12'h102, 12'h103 → four den pulses, then a single ch_valid with ch_data=32'h101 (sum 0x406 >> 2).
- TIMEOUT=8, DRP model never answers for ch1 (NUM_CH=3):
  - timeout_err=1 and timeout_ch=1 exactly 8 cycles after that den.
  - ch_data[1] is unchanged.
  - The next den targets ch2, and ch0/ch2 keep updating.
- enable dropped while in WAIT: the current read completes and ch_valid pulses, then no further den. Re-raising enable resumes at the next channel index.
- reset_n asserted low during WAIT with drdy arriving 1 cycle later: all outputs read their reset values, no ch_valid is generated, and after release the first den uses daddr=CH_ADDR[6:0].
- Spurious drdy while in IDLE with data 16'hFFF0: no ch_data change and no ch_valid.
